demux_1to7_buf: RTL and testbench

Registered 1-to-7 demultiplexer with valid/ready handshake on both sides. It carries one 32-bit datapath value to exactly one of seven destination ports, chosen by a 4-bit select. It is the distribution counterpart of the 7:1 datapath selector and sits between a producer (for example ALU or writeback result) and seven consumers. Out-of-range selects are consumed and dropped, with an error pulse and a saturating drop count.

---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_1to7_buf_skid_buf.sv | 40 ++++
 rtl/demux_1to7_buf.sv | 128 ++++++++++++
 tb/tb_demux_1to7_buf.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants, FSM state encoding and select decode for the 1-to-7 demux.
package demux_pkg;

  localparam int DATA_W = 32;
  localparam int N_DEST = 7;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  // Out-of-range selects decode to no destination at all.
  function automatic logic [6:0] onehot7(input logic [SEL_W-1:0] sel);
    if (sel > SEL_W'(6)) return 7'b0;
    return 7'b1 << sel;
  endfunction

endpackage

// File: rtl/demux_1to7_buf_skid_buf.sv
// One-entry data+select holding register: i_valid loads an entry, i_ready pops it.
module skid_buf #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [SEL_W-1:0]  o_sel
);
  import demux_pkg::*;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_sel;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (i_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sel   <= i_sel;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sel   = r_sel;

endmodule

// File: rtl/demux_1to7_buf.sv
// Registered 1-to-7 demux with valid/ready on both sides, invalid-select drop counting.
// Optional second (skid) entry, which removes the i_ready->o_ready path, under DEMUX_SKID_EN.
module demux_1to7_buf #(
  parameter int DATA_W = demux_pkg::DATA_W,
  parameter int N_DEST = demux_pkg::N_DEST,
  parameter int SEL_W  = demux_pkg::SEL_W,
  parameter int CNT_W  = demux_pkg::CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [N_DEST-1:0] o_valid,
  input  logic [N_DEST-1:0] i_ready,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic [1:0]        o_dbg_state
);
  import demux_pkg::*;

  // Handshake: a beat moves on a side whenever valid and ready are both high in
  // the same cycle; a beat offered on the output is held until it is taken.
  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic              r_err;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              w_deliver, w_accept, w_sel_ok, w_drop;

  assign o_valid   = (r_state == EMPTY) ? '0 : onehot7(r_sel);
  assign w_deliver = |(o_valid & i_ready);
  assign w_accept  = i_valid && o_ready;
  assign w_sel_ok  = (i_sel < SEL_W'(N_DEST));
  assign w_drop    = w_accept && !w_sel_ok;

`ifdef DEMUX_SKID_EN
  logic              w_skid_load, w_skid_pop, w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [SEL_W-1:0]  w_skid_sel;

  // Skid entry occupancy is a flop, so o_ready never depends on i_ready.
  assign o_ready     = i_rst_n && !w_skid_valid;
  assign w_skid_load = w_accept && w_sel_ok && (r_state == FULL) && !w_deliver;
  assign w_skid_pop  = (r_state == SKID) && w_deliver;

  skid_buf #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (w_skid_load),
    .i_data  (i_data),
    .i_sel   (i_sel),
    .i_ready (w_skid_pop),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_sel   (w_skid_sel)
  );
`else
  assign o_ready = i_rst_n && ((r_state == EMPTY) || w_deliver);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_sel_nxt   = r_sel;
    case (r_state)
      EMPTY: begin
        if (w_accept && w_sel_ok) begin
          w_state_nxt = FULL;
          w_data_nxt  = i_data;
          w_sel_nxt   = i_sel;
        end
      end
      FULL: begin
        if (w_accept && w_sel_ok) begin
`ifdef DEMUX_SKID_EN
          if (w_deliver) begin
            w_data_nxt = i_data;
            w_sel_nxt  = i_sel;
          end else begin
            w_state_nxt = SKID;
          end
`else
          w_data_nxt = i_data;
          w_sel_nxt  = i_sel;
`endif
        end else if (w_deliver) begin
          // Covers a dropped beat accepted alongside the deliver as well.
          w_state_nxt = EMPTY;
        end
      end
`ifdef DEMUX_SKID_EN
      SKID: begin
        if (w_deliver) begin
          w_state_nxt = FULL;
          w_data_nxt  = w_skid_data;
          w_sel_nxt   = w_skid_sel;
        end
      end
`endif
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= EMPTY;
      r_data     <= '0;
      r_sel      <= '0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
      r_err   <= w_drop;
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign o_data      = r_data;
  assign o_err       = r_err;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_demux_1to7_buf.sv
// Directed bench for demux_1to7_buf: queue-based reference model checked every cycle
// plus literal expectations for each scenario.
module tb_demux_1to7_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_data = '0;
  logic [3:0]  i_sel = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] o_data;
  logic [6:0]  o_valid;
  logic [6:0]  i_ready = 7'h7F;
  logic        o_err;
  logic [7:0]  o_drop_cnt;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  demux_1to7_buf dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (i_data),
    .i_sel       (i_sel),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_err       (o_err),
    .o_drop_cnt  (o_drop_cnt),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats held by the block, oldest first, as {sel, data}.
  logic [35:0] exp_q[$];
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;
  logic [7:0]  m_cnt = '0;

  function automatic logic m_deliver();
    return (exp_q.size() > 0) && i_ready[exp_q[0][35:32]];
  endfunction

  function automatic logic m_ready();
    if (!rst_n) return 1'b0;
`ifdef DEMUX_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || m_deliver();
`endif
  endfunction

  function automatic logic [6:0] m_valid();
    if (exp_q.size() == 0) return 7'd0;
    return 7'(1) << exp_q[0][35:32];
  endfunction

  always @(posedge clk) begin
    logic dlv, acc;
    if (!rst_n) begin
      exp_q.delete();
      m_data = '0;
      m_err  = 1'b0;
      m_cnt  = '0;
    end else begin
      dlv = m_deliver();
      acc = i_valid && m_ready();
      if (dlv) void'(exp_q.pop_front());
      m_err = 1'b0;
      if (acc) begin
        if (i_sel < 4'd7) exp_q.push_back({i_sel, i_data});
        else begin
          m_err = 1'b1;
          if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end
      end
      if (exp_q.size() > 0) m_data = exp_q[0][31:0];
    end
  end

  // Scoreboard compare, every cycle once reset has been applied
  always @(negedge clk) begin
    if (check_en) begin
      chk("sb_valid", o_valid, m_valid());
      chk("sb_data", o_data, m_data);
      chk("sb_ready", o_ready, m_ready());
      chk("sb_err", o_err, m_err);
      chk("sb_drop_cnt", o_drop_cnt, m_cnt);
    end
  end

  // Driver tasks
  task automatic wait_accept();
    logic r;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      r = o_ready;
      @(posedge clk); #1;
      if (r) begin
        i_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: beat sel=%0d not accepted within 50 cycles", i_sel);
    i_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] sel, input logic [31:0] data);
    i_valid = 1'b1;
    i_sel   = sel;
    i_data  = data;
    wait_accept();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic acc;
    @(posedge clk); #1;
    check_en = 1'b1;
    idle(2);
    rst_n = 1'b1;

    // Reset state then a single beat
    @(negedge clk);
    chk("rst_valid", o_valid, 7'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_cnt", o_drop_cnt, 8'd0);
    chk("rst_ready", o_ready, 1'b1);
    @(posedge clk); #1;
    i_valid = 1'b1; i_sel = 4'd3; i_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", o_valid, 7'b0001000);
    chk("single_data", o_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_empty", o_valid, 7'd0);
    @(posedge clk); #1;

    // Backpressure on destination 5 with a second beat waiting
    i_ready = 7'h5F;
    send(4'd5, 32'hA5A5_0001);
    i_valid = 1'b1; i_sel = 4'd1; i_data = 32'h1111_1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_valid", o_valid, 7'b0100000);
      chk("bp_data", o_data, 32'hA5A5_0001);
`ifdef DEMUX_SKID_EN
      chk("bp_ready", o_ready, (c == 0));
`else
      chk("bp_ready", o_ready, 1'b0);
`endif
      acc = o_ready;
      @(posedge clk); #1;
      if (acc) i_valid = 1'b0;
    end
    i_ready = 7'h7F;
    if (i_valid) wait_accept();
    idle(3);

    // Streaming 0..6 back to back
    for (int k = 0; k < 7; k++) begin
      i_valid = 1'b1; i_sel = 4'(k); i_data = 32'h100 + 32'(k);
      if (k > 0) begin
        @(negedge clk);
        chk("stream_valid", o_valid, 7'(1) << (k - 1));
        chk("stream_data", o_data, 32'h100 + 32'(k - 1));
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", o_valid, 7'b1000000);
    chk("stream_last_data", o_data, 32'h106);
    idle(2);

    // Invalid selects 9 and 15
    i_valid = 1'b1; i_sel = 4'd9; i_data = 32'hBAD0_0009;
    @(posedge clk); #1;
    i_sel = 4'd15; i_data = 32'hBAD0_000F;
    @(negedge clk);
    chk("inv9_err", o_err, 1'b1);
    chk("inv9_valid", o_valid, 7'd0);
    chk("inv9_cnt", o_drop_cnt, 8'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("inv15_err", o_err, 1'b1);
    chk("inv15_cnt", o_drop_cnt, 8'd2);
    chk("inv15_data", o_data, 32'h106);
    @(negedge clk);
    chk("inv_err_clear", o_err, 1'b0);
    chk("inv_cnt_hold", o_drop_cnt, 8'd2);
    @(posedge clk); #1;

    // 300 invalid beats saturate the counter
    i_valid = 1'b1; i_sel = 4'd12;
    for (int k = 0; k < 300; k++) begin
      i_data = 32'(k);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    @(negedge clk);
    chk("sat_cnt", o_drop_cnt, 8'd255);
    @(posedge clk); #1;

    // Simultaneous deliver (sel 2) and accept (sel 6)
    i_valid = 1'b1; i_sel = 4'd2; i_data = 32'h2222_2222;
    @(posedge clk); #1;
    i_sel = 4'd6; i_data = 32'h6666_6666;
    @(negedge clk);
    chk("sim_valid_a", o_valid, 7'b0000100);
    chk("sim_ready", o_ready, 1'b1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("sim_valid_b", o_valid, 7'b1000000);
    chk("sim_data_b", o_data, 32'h6666_6666);
    idle(2);

    // Reset while holding a beat that nobody takes
    i_ready = 7'h00;
    send(4'd4, 32'hCAFE_0004);
    @(negedge clk);
    chk("mid_valid_before", o_valid, 7'b0010000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_ready_in_rst", o_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_valid_after", o_valid, 7'd0);
    chk("mid_data_after", o_data, 32'd0);
    chk("mid_cnt_after", o_drop_cnt, 8'd0);
    @(posedge clk); #1;
    i_ready = 7'h7F;
    send(4'd0, 32'h0000_00AA);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
